// File: rtl/fwd_dispatch_if.sv
// Ingress FIFO pop side, shared egress FIFO fan-out, lookup result and frame counters
// of one store-and-forward dispatch port.
interface fwd_dispatch_if #(
  parameter int NPORT = 4'h4
);
  logic [8:0]       rx_dout;
  logic             rx_empty;
  logic             rx_rd_en;
  logic [15:0]      of_lookup_fwd_port;
  logic [8:0]       tx_din;
  logic [NPORT-1:0] tx_wr_en;
  logic [NPORT-1:0] tx_full;
  logic [15:0]      fwd_cnt;
  logic [15:0]      drop_cnt;

  modport master (
    input  rx_dout, rx_empty, of_lookup_fwd_port, tx_full,
    output rx_rd_en, tx_din, tx_wr_en, fwd_cnt, drop_cnt
  );

  modport slave (
    output rx_dout, rx_empty, of_lookup_fwd_port, tx_full,
    input  rx_rd_en, tx_din, tx_wr_en, fwd_cnt, drop_cnt
  );
endinterface

// File: rtl/fwd_dispatch.sv
// Store-and-forward frame dispatcher: buffers one whole ingress frame, then replicates it
// (plus a trailing gap word) to every egress port in the lookup mask except its own.
module fwd_dispatch #(
  parameter int NPORT    = 4'h4,
  parameter int PORT_NUM = 4'h0
) (
  input logic            sys_clk,
  input logic            sys_rst,
  fwd_dispatch_if.master bus
);
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  typedef enum logic [2:0] {IDLE, RECV, DECIDE, TX, TX_END} state_t;

  state_t           state, state_nxt;
  logic [8:0]       buf_mem [DEPTH];
  logic [AW:0]      len;
  logic [AW-1:0]    rd_ptr;
  logic             ovf;
  logic [NPORT-1:0] mask, mask_dec;
  logic             rd_en_p0;
  logic [8:0]       din_p1;
  logic [NPORT-1:0] vld_p1;
  logic [15:0]      fwd_cnt, drop_cnt;
  logic             take, byte_in, tx_ok, last, buf_we;
  logic [AW-1:0]    buf_wa;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign take    = rd_en_p0 & ~bus.rx_empty;
  assign byte_in = take & bus.rx_dout[8];
  assign tx_ok   = ((bus.tx_full & mask) == '0);
  assign last    = ({1'b0, rd_ptr} == len - 12'd1);
  assign buf_we  = byte_in & ((state == IDLE) | ((state == RECV) & (len != 12'(DEPTH))));
  assign buf_wa  = (state == IDLE) ? '0 : len[AW-1:0];

  // Own port is never a destination, so a frame cannot hairpin back out of its ingress.
  always_comb begin
    mask_dec = '0;
    for (int i = 0; i < NPORT; i++)
      if (i < 4 && i != PORT_NUM) mask_dec[i] = bus.of_lookup_fwd_port[4*PORT_NUM + i];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (byte_in) state_nxt = RECV;
      RECV:    if (take && !bus.rx_dout[8]) state_nxt = DECIDE;
      DECIDE:  state_nxt = (mask_dec == '0 || ovf) ? IDLE : TX;
      TX:      if (tx_ok && last) state_nxt = TX_END;
      TX_END:  if (tx_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (buf_we) buf_mem[buf_wa] <= bus.rx_dout;
  end

  // Stage p0 -> p1: pop enable follows the next state; egress word and strobes registered together.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      len      <= '0;
      rd_ptr   <= '0;
      ovf      <= 1'b0;
      mask     <= '0;
      rd_en_p0 <= 1'b0;
      din_p1   <= '0;
      vld_p1   <= '0;
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      rd_en_p0 <= (state_nxt == IDLE) || (state_nxt == RECV);
      vld_p1   <= '0;
      case (state)
        IDLE: if (byte_in) len <= 12'd1;
        RECV: begin
          if (byte_in) begin
            if (len == 12'(DEPTH)) ovf <= 1'b1;
            else                   len <= len + 12'd1;
          end
        end
        DECIDE: begin
          if (mask_dec == '0 || ovf) begin
            drop_cnt <= sat_inc(drop_cnt);
            ovf      <= 1'b0;
          end else begin
            mask   <= mask_dec;
            rd_ptr <= '0;
          end
        end
        TX: begin
          if (tx_ok) begin
            vld_p1 <= mask;
            din_p1 <= buf_mem[rd_ptr];
            rd_ptr <= rd_ptr + 11'd1;
          end
        end
        TX_END: begin
          if (tx_ok) begin
            vld_p1  <= mask;
            din_p1  <= 9'h000;
            fwd_cnt <= sat_inc(fwd_cnt);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_rd_en = rd_en_p0;
  assign bus.tx_din   = din_p1;
  assign bus.tx_wr_en = vld_p1;
  assign bus.fwd_cnt  = fwd_cnt;
  assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_fwd_dispatch.sv
// Directed bench for fwd_dispatch: FWFT ingress queue model, per-port egress capture queues.
module tb_fwd_dispatch;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   overlap = 0;
  int   first_w [4];
  int   last_w  [4];

  logic [8:0] rxq[$];
  logic [8:0] q0[$], q1[$], q2[$], q3[$];

  fwd_dispatch_if #(.NPORT(4)) bus ();

  fwd_dispatch #(.NPORT(4), .PORT_NUM(0)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc++;
    if (bus.rx_rd_en && !bus.rx_empty && rxq.size() > 0) void'(rxq.pop_front());
  end

  task automatic push_q(input int p, input logic [8:0] w);
    case (p)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic pop_q(input int p, output logic [8:0] w);
    case (p)
      0: w = q0.pop_front();
      1: w = q1.pop_front();
      2: w = q2.pop_front();
      default: w = q3.pop_front();
    endcase
  endtask

  always @(negedge sys_clk) begin
    bus.rx_empty = (rxq.size() == 0);
    bus.rx_dout  = (rxq.size() > 0) ? rxq[0] : 9'h000;
    for (int p = 0; p < 4; p++) begin
      if (bus.tx_wr_en[p]) begin
        push_q(p, bus.tx_din);
        if (first_w[p] < 0) first_w[p] = cyc;
        last_w[p] = cyc;
      end
    end
    if (bus.tx_wr_en != 4'b0 && bus.tx_din[8] && bus.rx_rd_en) overlap++;
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int n, input int base);
    for (int i = 0; i < n; i++) rxq.push_back({1'b1, 8'(base + i)});
    rxq.push_back(9'h000);
  endtask

  task automatic clr_marks();
    for (int p = 0; p < 4; p++) begin
      first_w[p] = -1;
      last_w[p]  = -1;
    end
  endtask

  // Pops n bytes plus the trailing gap word from port p and counts wrong or missing words.
  task automatic check_seq(input string tag, input int p, input int n, input int base);
    logic [8:0] w;
    int bad = 0;
    for (int i = 0; i <= n; i++) begin
      if (qsize(p) == 0) bad++;
      else begin
        pop_q(p, w);
        if (w !== ((i == n) ? 9'h000 : {1'b1, 8'(base + i)})) bad++;
      end
    end
    chk(tag, bad, 0);
  endtask

  task automatic wait_fwd(input string tag, input int target, input int limit);
    for (int i = 0; i < limit && bus.fwd_cnt != 16'(target); i++) step();
    step();
    step();
    chk(tag, bus.fwd_cnt, target);
  endtask

  task automatic wait_drop(input string tag, input int target, input int limit);
    for (int i = 0; i < limit && bus.drop_cnt != 16'(target); i++) step();
    step();
    step();
    chk(tag, bus.drop_cnt, target);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " q0"}, qsize(0), 0);
    chk({tag, " q1"}, qsize(1), 0);
    chk({tag, " q2"}, qsize(2), 0);
    chk({tag, " q3"}, qsize(3), 0);
  endtask

  initial begin
    logic [8:0] w;
    int zeros;
    int waited;
    clr_marks();
    bus.tx_full            = 4'b0;
    bus.of_lookup_fwd_port = 16'h0;
    bus.rx_empty           = 1'b1;
    bus.rx_dout            = 9'h000;

    // Reset values
    repeat (3) step();
    chk("rst rx_rd_en", bus.rx_rd_en, 0);
    chk("rst tx_wr_en", bus.tx_wr_en, 0);
    chk("rst tx_din", bus.tx_din, 9'h000);
    chk("rst fwd_cnt", bus.fwd_cnt, 0);
    chk("rst drop_cnt", bus.drop_cnt, 0);
    sys_rst = 1'b1;
    step();
    chk("rx_rd_en after rst", bus.rx_rd_en, 1);

    // 64-byte frame to ports 1 and 3
    bus.of_lookup_fwd_port = 16'h000A;
    push_frame(64, 8'h00);
    wait_fwd("fwd 64B", 1, 400);
    check_seq("port1 64B", 1, 64, 8'h00);
    check_seq("port3 64B", 3, 64, 8'h00);
    check_quiet("after 64B");

    // Own-port-only mask drops, next frame still flows
    bus.of_lookup_fwd_port = 16'h0001;
    push_frame(10, 8'h20);
    wait_drop("drop hairpin", 1, 200);
    check_quiet("hairpin");
    bus.of_lookup_fwd_port = 16'h0004;
    push_frame(5, 8'h80);
    wait_fwd("fwd after drop", 2, 200);
    check_seq("port2 5B", 2, 5, 8'h80);
    check_quiet("after 5B");

    // Oversize frame dropped, following frame intact
    bus.of_lookup_fwd_port = 16'h0002;
    push_frame(2100, 8'h00);
    wait_drop("drop oversize", 2, 5000);
    check_quiet("oversize");
    chk("oversize rx drained", rxq.size(), 0);
    push_frame(60, 8'h10);
    wait_fwd("fwd after oversize", 3, 400);
    check_seq("port1 60B", 1, 60, 8'h10);

    // Back-pressure on port 2 stalls both masked ports
    clr_marks();
    bus.of_lookup_fwd_port = 16'h0006;
    push_frame(40, 8'h40);
    waited = 0;
    while (qsize(1) < 10 && waited < 300) begin
      step();
      waited++;
    end
    chk("reach mid-frame", (qsize(1) >= 10), 1);
    bus.tx_full = 4'b0100;
    repeat (5) step();
    bus.tx_full = 4'b0000;
    wait_fwd("fwd stalled", 4, 400);
    chk("port1 span", last_w[1] - first_w[1] + 1, 46);
    chk("port2 span", last_w[2] - first_w[2] + 1, 46);
    check_seq("port1 stalled", 1, 40, 8'h40);
    check_seq("port2 stalled", 2, 40, 8'h40);
    check_quiet("after stall");

    // Back-to-back frames, ingress never empty
    overlap = 0;
    bus.of_lookup_fwd_port = 16'h0008;
    push_frame(30, 8'hA0);
    push_frame(20, 8'hC0);
    wait_fwd("fwd back-to-back", 6, 600);
    chk("rx pop during tx", overlap, 0);
    check_seq("port3 frame A", 3, 30, 8'hA0);
    check_seq("port3 frame B", 3, 20, 8'hC0);
    check_quiet("after b2b");

    // Reset in the middle of TX
    bus.of_lookup_fwd_port = 16'h0002;
    push_frame(50, 8'h00);
    waited = 0;
    while (qsize(1) < 20 && waited < 300) begin
      step();
      waited++;
    end
    chk("reach byte 20", qsize(1), 20);
    sys_rst = 1'b0;
    step();
    chk("midrst tx_wr_en", bus.tx_wr_en, 0);
    chk("midrst tx_din", bus.tx_din, 9'h000);
    chk("midrst rx_rd_en", bus.rx_rd_en, 0);
    chk("midrst fwd_cnt", bus.fwd_cnt, 0);
    chk("midrst drop_cnt", bus.drop_cnt, 0);
    step();
    sys_rst = 1'b1;
    repeat (3) step();
    zeros = 0;
    while (qsize(1) > 0) begin
      pop_q(1, w);
      if (w == 9'h000) zeros++;
    end
    chk("no gap after abort", zeros, 0);
    check_quiet("after abort");
    push_frame(12, 8'h55);
    wait_fwd("fwd after rst", 1, 200);
    check_seq("port1 after rst", 1, 12, 8'h55);
    check_quiet("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fwd_dispatch.md
FWD_DISPATCH -- requirements
Module: fwd_dispatch

Interface
REQ-001 Parameter NPORT, default 4'h4, number of output ports (tx_wr_en/tx_full width).
REQ-002 Parameter PORT_NUM, default 4'h0, index of the ingress port this instance serves; selects the nibble of of_lookup_fwd_port.
REQ-003 sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 rx_dout  input  9  ingress FIFO word; bit8=1 frame byte in [7:0], bit8=0 inter-frame gap word.
REQ-006 rx_empty  input  1  ingress FIFO empty.
REQ-007 rx_rd_en  output  1  ingress pop; first-word-fall-through, one word consumed per edge with rx_rd_en=1 and rx_empty=0.
REQ-008 of_lookup_fwd_port  input  16  lookup result, nibble [4*PORT_NUM+3:4*PORT_NUM] is this port's destination mask.
REQ-009 tx_din  output  9  egress word, shared by all egress FIFOs.
REQ-010 tx_wr_en  output  NPORT  per-port egress write strobe.
REQ-011 tx_full  input  NPORT  per-port egress almost-full, at least one free entry remaining when asserted.
REQ-012 fwd_cnt  output  16  frames forwarded, saturating.
REQ-013 drop_cnt  output  16  frames dropped, saturating.

Function
REQ-014 Store-and-forward: internal buffer 2048 x 9; a frame is fully received before any egress write.
REQ-015 States: IDLE, RECV, DECIDE, TX, TX_END; state register only, no other sequencing state.
REQ-016 rx_rd_en = 1 in IDLE and RECV, 0 in all other states; decoded from the state register only, with no combinational path from inputs.
REQ-017 IDLE: consumed words with bit8=0 are discarded; a consumed word with bit8=1 is written at address 0, len=1, and the state goes to RECV.
REQ-018 RECV, consumed word with bit8=1 and len<2048: write at address len, len+1.
REQ-019 RECV, consumed word with bit8=1 and len=2048: word discarded, ovf flag set.
REQ-020 RECV, consumed word with bit8=0: the state goes to DECIDE; because of REQ-016 no further word is consumed.
REQ-021 RECV, rx_empty=1: state held, nothing written.
REQ-022 DECIDE (exactly 1 cycle): mask = low NPORT bits of the selected nibble, with bit PORT_NUM forced to 0 (no hairpin).
REQ-023 DECIDE, mask=0 or ovf=1: drop_cnt+1 (saturate at 16'hFFFF), clear ovf, go to IDLE.
REQ-024 DECIDE, otherwise: latch mask, rd_ptr=0, go to TX.
REQ-025 TX, write condition: advance only at an edge where (tx_full & mask)==0.
REQ-026 TX, write timing: tx_wr_en=mask and tx_din=buffer[rd_ptr] with bit8=1 are registered, valid the cycle after the advancing edge.
REQ-027 TX, stall cycles: tx_wr_en=0.
REQ-028 TX, unmasked ports: never written.
REQ-029 TX, after word len-1 is issued: go to TX_END.
REQ-030 Throughput: 1 byte/cycle absent back-pressure; buffer read latency hidden, so the first egress write occurs 2 cycles after entering TX.
REQ-031 TX_END: issue one gap word tx_din=9'h000 to the masked ports under the same full rule, then fwd_cnt+1 (saturate) and go to IDLE.
REQ-032 tx_wr_en is 0 in IDLE, RECV and DECIDE.
REQ-033 Ingress is back-pressured (rx_rd_en=0) for the whole of DECIDE/TX/TX_END; no ingress word is lost or reordered.
REQ-034 of_lookup_fwd_port is sampled only in DECIDE; changes in other states have no effect.

Reset
REQ-035 While sys_rst=0 at an edge: state=IDLE, len=0, rd_ptr=0, ovf=0, mask=0.
REQ-036 While sys_rst=0 at an edge: rx_rd_en=0, tx_wr_en=0, tx_din=9'h000, fwd_cnt=0, drop_cnt=0.
REQ-037 Buffer contents need no reset.
REQ-038 Reset asserted mid-frame (RECV or TX) aborts the frame: no partial TX_END gap word is issued and no counter is updated.
REQ-039 First rx_rd_en=1 occurs in the first cycle after sys_rst returns to 1.

Verification
REQ-040 PORT_NUM=0, 64-byte frame 00..3F then gap, lookup nibble0=4'b1010, no full -> ports 1 and 3 receive 64 words {1,00}..{1,3F} then 9'h000; port 0 and port 2 untouched; fwd_cnt=1.
REQ-041 Nibble0=4'b0001 (own port only) -> mask 0, no tx_wr_en, drop_cnt=1, next frame accepted normally.
REQ-042 2100-byte frame -> nothing written, drop_cnt=1, rx stream consumed through the gap word; a following 60-byte frame is forwarded intact.
REQ-043 Mask 4'b0110, tx_full[2] high for 5 cycles mid-frame -> ports 1 and 2 both stall 5 cycles; identical byte sequences with no duplicates or gaps.
REQ-044 Two back-to-back frames, rx_empty never high -> second frame waits with rx_rd_en=0 during TX; both frames delivered in order; fwd_cnt=2.
REQ-045 sys_rst=0 asserted at byte 20 of TX -> all outputs at reset values next cycle; a subsequent frame is forwarded correctly from address 0.
